// File: rtl/func_spc_stream_pkg.sv
// Shared types and defaults for the SPC node decoder (func_spc_stream).
// Optional min-output ports are enabled by the macro FUNC_SPC_MIN_OUT_EN.
package func_spc_stream_pkg;

  localparam int FSPC_LLR_W_DEF = 6;
  localparam int FSPC_P_DEF     = 16;
  localparam int FSPC_MAX_N_DEF = 64;

  typedef enum logic [1:0] {
    FSPC_IDLE = 2'd0,
    FSPC_ACC  = 2'd1,
    FSPC_FIX  = 2'd2,
    FSPC_OUT  = 2'd3
  } fspc_state_e;

  // Width of an index into v items, never below one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/func_spc_stream_min_tree.sv
// Combinational pairwise min-|LLR| over P lanes with lane index.
// On equal magnitudes the lower lane wins; disabled lanes never win.
module spc_min_tree
  import func_spc_stream_pkg::*;
#(
  parameter int  LLR_W = FSPC_LLR_W_DEF,
  parameter int  P     = FSPC_P_DEF,
  localparam int LP_W  = clog2_min1(P)
) (
  input  logic [P*LLR_W-1:0] llr_i,
  input  logic [P-1:0]       lane_en_i,
  output logic [LLR_W-1:0]   min_abs_o,
  output logic [LP_W-1:0]    min_lane_o,
  output logic               min_valid_o
);

  localparam int LOG_P = $clog2(P);

  always_comb begin
    logic [LLR_W-1:0] abs_l [LOG_P+1][P];
    logic [LP_W-1:0]  idx_l [LOG_P+1][P];
    logic [P-1:0]     v_l   [LOG_P+1];
    logic [LLR_W-1:0] x;
    logic             take_b;

    // NOTE: every variable gets a default before the loops so no latch is inferred.
    x      = '0;
    take_b = 1'b0;
    for (int l = 0; l <= LOG_P; l++) begin
      v_l[l] = '0;
      for (int k = 0; k < P; k++) begin
        abs_l[l][k] = '0;
        idx_l[l][k] = '0;
      end
    end

    // Unsigned magnitude: the most negative code maps to 2^(LLR_W-1) exactly.
    for (int j = 0; j < P; j++) begin
      x           = llr_i[j*LLR_W +: LLR_W];
      abs_l[0][j] = x[LLR_W-1] ? ((~x) + LLR_W'(1)) : x;
      idx_l[0][j] = LP_W'(j);
      v_l[0][j]   = lane_en_i[j];
    end

    for (int l = 0; l < LOG_P; l++) begin
      for (int k = 0; k < (P >> (l + 1)); k++) begin
        take_b = v_l[l][2*k+1] &&
                 (!v_l[l][2*k] || (abs_l[l][2*k+1] < abs_l[l][2*k]));
        abs_l[l+1][k] = take_b ? abs_l[l][2*k+1] : abs_l[l][2*k];
        idx_l[l+1][k] = take_b ? idx_l[l][2*k+1] : idx_l[l][2*k];
        v_l[l+1][k]   = v_l[l][2*k] | v_l[l][2*k+1];
      end
    end

    min_abs_o   = abs_l[LOG_P][0];
    min_lane_o  = idx_l[LOG_P][0];
    min_valid_o = v_l[LOG_P][0];
  end

endmodule

// File: rtl/func_spc_stream.sv
// Multi-beat single-parity-check node decoder: hard decisions, parity, min-|LLR| flip.
// Define FUNC_SPC_MIN_OUT_EN to expose the final min magnitude and index.
module func_spc_stream
  import func_spc_stream_pkg::*;
#(
  parameter int  LLR_W   = FSPC_LLR_W_DEF,
  parameter int  P       = FSPC_P_DEF,
  parameter int  MAX_N   = FSPC_MAX_N_DEF,
  localparam int MAX_LOG = $clog2(MAX_N),
  localparam int NL_W    = $clog2(MAX_LOG + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NL_W-1:0]      in_n_log,
  input  logic [P*LLR_W-1:0]   in_llr,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef FUNC_SPC_MIN_OUT_EN
  output logic [LLR_W-1:0]     out_min_abs,
  output logic [MAX_LOG-1:0]   out_min_idx,
`endif
  output logic [MAX_N-1:0]     out_bits
);

  localparam int LOG_P     = $clog2(P);
  localparam int BEATS_MAX = MAX_N / P;
  localparam int CNT_W     = clog2_min1(BEATS_MAX);
  localparam int LP_W      = clog2_min1(P);

  fspc_state_e        state_q;
  logic [NL_W-1:0]    n_log_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               parity_q;
  logic [LLR_W-1:0]   min_abs_q;
  logic [MAX_LOG-1:0] min_idx_q;
  logic [MAX_N-1:0]   bits_q;
  logic               out_valid_q;

  logic [NL_W-1:0]    n_clamp;
  logic [NL_W-1:0]    n_cur;
  logic [CNT_W-1:0]   cur_beat;
  logic [CNT_W-1:0]   beats_m1;
  logic [P-1:0]       lane_en;
  logic [P-1:0]       beat_bits;
  logic               beat_par;
  logic [MAX_N-1:0]   bits_d;
  logic [LLR_W-1:0]   t_abs;
  logic [LP_W-1:0]    t_lane;
  logic               t_valid;
  logic [MAX_LOG-1:0] beat_idx;

  assign in_ready = (state_q == FSPC_IDLE) || (state_q == FSPC_ACC);

  // The first beat uses the clamped request; later beats reuse the latched size.
  always_comb begin
    n_clamp = in_n_log;
    if (in_n_log < NL_W'(2))            n_clamp = NL_W'(2);
    else if (in_n_log > NL_W'(MAX_LOG)) n_clamp = NL_W'(MAX_LOG);
    n_cur    = (state_q == FSPC_IDLE) ? n_clamp : n_log_q;
    cur_beat = (state_q == FSPC_IDLE) ? '0 : cnt_q;
    beats_m1 = '0;
    if (int'(n_cur) > LOG_P) beats_m1 = CNT_W'((1 << (int'(n_cur) - LOG_P)) - 1);
    for (int j = 0; j < P; j++) begin
      lane_en[j]   = ((j >> n_cur) == 0);
      beat_bits[j] = lane_en[j] & in_llr[j*LLR_W + LLR_W - 1];
    end
    beat_par = ^beat_bits;
    bits_d   = (state_q == FSPC_IDLE) ? '0 : bits_q;
    for (int k = 0; k < MAX_N; k++) begin
      if (((k >> LOG_P) == int'(cur_beat)) && lane_en[k % P])
        bits_d[k] = beat_bits[k % P];
    end
  end

  spc_min_tree #(
    .LLR_W (LLR_W),
    .P     (P)
  ) u_min_tree (
    .llr_i       (in_llr),
    .lane_en_i   (lane_en),
    .min_abs_o   (t_abs),
    .min_lane_o  (t_lane),
    .min_valid_o (t_valid)
  );

  assign beat_idx = MAX_LOG'((int'(cur_beat) << LOG_P) + int'(t_lane));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FSPC_IDLE;
      n_log_q     <= '0;
      cnt_q       <= '0;
      parity_q    <= 1'b0;
      min_abs_q   <= '0;
      min_idx_q   <= '0;
      // NOTE: the bit store is a plain flop vector, so it takes the async reset like any other state.
      bits_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      case (state_q)
        FSPC_IDLE: begin
          if (in_valid) begin
            n_log_q   <= n_clamp;
            bits_q    <= bits_d;
            parity_q  <= beat_par;
            min_abs_q <= t_abs;
            min_idx_q <= beat_idx;
            if (beats_m1 == '0) begin
              state_q <= FSPC_FIX;
            end else begin
              cnt_q   <= CNT_W'(1);
              state_q <= FSPC_ACC;
            end
          end
        end
        FSPC_ACC: begin
          if (in_valid) begin
            bits_q   <= bits_d;
            parity_q <= parity_q ^ beat_par;
            // Strict less-than keeps the earlier (lower) index on ties across beats.
            if (t_valid && (t_abs < min_abs_q)) begin
              min_abs_q <= t_abs;
              min_idx_q <= beat_idx;
            end
            if (cnt_q == beats_m1) begin
              cnt_q   <= '0;
              state_q <= FSPC_FIX;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        FSPC_FIX: begin
          if (parity_q) bits_q[min_idx_q] <= ~bits_q[min_idx_q];
          out_valid_q <= 1'b1;
          state_q     <= FSPC_OUT;
        end
        FSPC_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= FSPC_IDLE;
          end
        end
        default: state_q <= FSPC_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_bits  = bits_q;
`ifdef FUNC_SPC_MIN_OUT_EN
  assign out_min_abs = min_abs_q;
  assign out_min_idx = min_idx_q;
`endif

endmodule
